// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard scan-code receiver.
// Synchronises ps2_clk/ps2_data, deframes 11-bit frames (start, 8 data LSB
// first, odd parity, stop) and folds 0xF0 / 0xE0 prefixes into key_break /
// key_ext flags that accompany the following code on the code_valid strobe.
// Optional feature macro: PS2_PARITY_CHECK_EN (parity mismatch -> frame_err).
module ps2_scan_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_clk_sync;
  logic [SYNC_STAGES-1:0]  r_data_sync;
  logic                    r_clk_prev;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift;
  logic [CW-1:0]           r_idle_cnt;
  logic                    r_break_pend;
  logic                    r_ext_pend;
  logic [7:0]              r_code;
  logic                    r_code_valid;
  logic                    r_key_break;
  logic                    r_key_ext;
  logic                    r_frame_err;

  logic                    w_clk_s;
  logic                    w_data_s;
  logic                    w_fall;
  logic                    w_frame_ok;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  logic w_par_ok;
  assign w_par_ok   = ^{r_shift, r_parity};
  assign w_frame_ok = w_data_s & w_par_ok;
`else
  assign w_frame_ok = w_data_s;
`endif

  // Synchronisers; reset to idle-high so reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Parity bit capture for the odd-parity check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_parity <= 1'b0;
    else if (w_fall && r_state == PARITY)
      r_parity <= w_data_s;
  end
`endif

  // Frame FSM, idle-timeout counter, prefix tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_idle_cnt   <= '0;
      r_break_pend <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_key_break  <= 1'b0;
      r_key_ext    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == IDLE) begin
        r_idle_cnt <= '0;
        if (w_fall && !w_data_s) begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
        end
      end else if (w_fall) begin
        r_idle_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shift <= {w_data_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7)
              r_state <= PARITY;
            else
              r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: r_state <= STOP;
          STOP: begin
            r_state <= IDLE;
            if (w_frame_ok) begin
              if (r_shift == 8'hF0)
                r_break_pend <= 1'b1;
              else if (r_shift == 8'hE0)
                r_ext_pend <= 1'b1;
              else begin
                r_code       <= r_shift;
                r_key_break  <= r_break_pend;
                r_key_ext    <= r_ext_pend;
                r_code_valid <= 1'b1;
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
              end
            end else begin
              r_frame_err  <= 1'b1;
              r_break_pend <= 1'b0;
              r_ext_pend   <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_idle_cnt == CW'(TIMEOUT_CYC)) begin
        r_state      <= IDLE;
        r_idle_cnt   <= '0;
        r_frame_err  <= 1'b1;
        r_break_pend <= 1'b0;
        r_ext_pend   <= 1'b0;
      end else begin
        r_idle_cnt <= r_idle_cnt + CW'(1);
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign key_break  = r_key_break;
  assign key_ext    = r_key_ext;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed testbench for ps2_scan_receiver (short timeout for fast runs).
module tb_ps2_scan_receiver;

  localparam int TOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;

  int total = 0;
  int bad = 0;

  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int n_wide = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] last_code = '0;
  logic last_brk = 1'b0;
  logic last_ext = 1'b0;

  ps2_scan_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .key_break(key_break),
    .key_ext(key_ext), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk) begin
    prev_valid <= code_valid;
    prev_err   <= frame_err;
    if (code_valid) begin
      n_valid   <= n_valid + 1;
      last_code <= code;
      last_brk  <= key_break;
      last_ext  <= key_ext;
    end
    if (frame_err) n_err <= n_err + 1;
    if (code_valid && frame_err) n_both <= n_both + 1;
    if ((code_valid && prev_valid) || (frame_err && prev_err)) n_wide <= n_wide + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send n bits LSB first; lat = negedges from the last falling edge until code_valid.
  task automatic send_bits(input logic [10:0] bits, input int n, output int lat);
    lat = -1;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (i == n - 1 && code_valid && lat < 0) lat = k;
      end
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    int lat;
    send_bits({stp, par, d, 1'b0}, 11, lat);
    wait_cyc(10);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    total++;
    if ({code, code_valid, key_break, key_ext, frame_err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got code=%h v=%b b=%b e=%b err=%b want all 0",
               code, code_valid, key_break, key_ext, frame_err);
    end
    rst_n = 1'b1;
    wait_cyc(10);
    total++;
    if (n_valid !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL reset_release got valid=%0d err=%0d want 0 0", n_valid, n_err);
    end
  endtask

  task automatic test_basic();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, lat);
    wait_cyc(10);
    total++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL basic_counts got valid=%0d err=%0d want 1 0", n_valid - v0, n_err - e0);
    end
    total++;
    if ({last_code, last_brk, last_ext} !== {8'h1C, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_code got %h b=%b e=%b want 1c 0 0", last_code, last_brk, last_ext);
    end
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL basic_latency got %0d want 3", lat);
    end
    total++;
    if (code !== 8'h1C) begin
      bad++;
      $display("FAIL basic_hold got %h want 1c", code);
    end
  endtask

  task automatic test_break();
    int v0;
    v0 = n_valid;
    send_frame(8'hF0, 1'b1, 1'b1);
    total++;
    if (n_valid - v0 !== 0) begin
      bad++;
      $display("FAIL break_prefix_novalid got %0d want 0", n_valid - v0);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 1 || {last_code, last_brk, last_ext} !== {8'h1C, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL break_code got n=%0d %h b=%b e=%b want 1 1c 1 0",
               n_valid - v0, last_code, last_brk, last_ext);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 2 || last_brk !== 1'b0 || key_break !== 1'b0) begin
      bad++;
      $display("FAIL break_cleared got n=%0d b=%b want 2 0", n_valid - v0, last_brk);
    end
  endtask

  task automatic test_ext();
    int v0;
    v0 = n_valid;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 1 || {last_code, last_brk, last_ext} !== {8'h75, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ext_break got n=%0d %h b=%b e=%b want 1 75 1 1",
               n_valid - v0, last_code, last_brk, last_ext);
    end
    total++;
    if ({code, key_break, key_ext} !== {8'h75, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ext_hold got %h b=%b e=%b want 75 1 1", code, key_break, key_ext);
    end
  endtask

  task automatic test_parity();
    int v0, e0;
    send_frame(8'h1C, 1'b0, 1'b1);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    total++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
      bad++;
      $display("FAIL parity_bad got valid=%0d err=%0d want 0 1", n_valid - v0, n_err - e0);
    end
`else
    total++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0 || last_code !== 8'h1C) begin
      bad++;
      $display("FAIL parity_ignored got valid=%0d err=%0d code=%h want 1 0 1c",
               n_valid - v0, n_err - e0, last_code);
    end
`endif
  endtask

  task automatic test_stop();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0);
    total++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 1 || code !== 8'h1C) begin
      bad++;
      $display("FAIL stop_bad got valid=%0d err=%0d code=%h want 0 1 1c",
               n_valid - v0, n_err - e0, code);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 1 || last_brk !== 1'b0) begin
      bad++;
      $display("FAIL stop_clears_pend got n=%0d b=%b want 1 0", n_valid - v0, last_brk);
    end
  endtask

  task automatic test_timeout();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    send_bits({6'b111111, 4'b0101, 1'b0}, 5, lat);
    wait_cyc(TOUT + 50);
    total++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
      bad++;
      $display("FAIL timeout got valid=%0d err=%0d want 0 1", n_valid - v0, n_err - e0);
    end
    send_frame(8'h29, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 1 || last_code !== 8'h29) begin
      bad++;
      $display("FAIL timeout_recover got valid=%0d err=%0d code=%h want 1 1 29",
               n_valid - v0, n_err - e0, last_code);
    end
  endtask

  task automatic test_reset_mid();
    int v0, e0, lat;
    send_bits({5'b11111, 5'b10110, 1'b0}, 6, lat);
    e0 = n_err;
    rst_n = 1'b0;
    wait_cyc(4);
    total++;
    if ({code, code_valid, key_break, key_ext, frame_err} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_outputs got code=%h v=%b b=%b e=%b err=%b want all 0",
               code, code_valid, key_break, key_ext, frame_err);
    end
    rst_n = 1'b1;
    wait_cyc(TOUT + 50);
    total++;
    if (n_err - e0 !== 0) begin
      bad++;
      $display("FAIL midreset_noerr got %0d want 0", n_err - e0);
    end
    v0 = n_valid;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (n_valid - v0 !== 1 || {last_code, last_brk, last_ext} !== {8'h1C, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_recover got n=%0d %h b=%b e=%b want 1 1c 0 0",
               n_valid - v0, last_code, last_brk, last_ext);
    end
  endtask

  task automatic test_strobes();
    total++;
    if (n_both !== 0 || n_wide !== 0) begin
      bad++;
      $display("FAIL strobe_shape got both=%0d wide=%0d want 0 0", n_both, n_wide);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_ext();
    test_parity();
    test_stop();
    test_timeout();
    test_reset_mid();
    test_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL expose the following parameters and ports.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on ps2_clk and ps2_data, minimum 2.
REQ-003 Parameter TIMEOUT_CYC, default 50000: clk cycles without a ps2_clk falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
REQ-004 Port clk, input, 1 bit: system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port ps2_clk, input, 1 bit: PS/2 device clock, asynchronous to clk.
REQ-007 Port ps2_data, input, 1 bit: PS/2 device data, asynchronous to clk.
REQ-008 Port code, output, 8 bits: last completed make/break scan code, feeding the downstream code-to-action translator.
REQ-009 Port code_valid, output, 1 bit: one-cycle strobe marking a new code.
REQ-010 Port key_break, output, 1 bit: code is a release (preceded by 0xF0); valid with code_valid.
REQ-011 Port key_ext, output, 1 bit: code is extended (preceded by 0xE0); valid with code_valid.
REQ-012 Port frame_err, output, 1 bit: one-cycle strobe for a discarded frame.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flip-flops; a falling edge SHALL be synced ps2_clk previous 1 and current 0.
REQ-014 The FSM SHALL have four states: IDLE, DATA, PARITY, STOP; all sampling SHALL occur only on a detected falling edge.
REQ-015 In IDLE: on an edge with data 0 (start bit), go to DATA with bit count 0; with data 1, stay in IDLE.
REQ-016 In DATA: shift data into the byte LSB first; after the 8th bit, go to PARITY.
REQ-017 In PARITY: capture the parity bit and go to STOP.
REQ-018 In STOP: if the stop bit is 1 and the parity check passes, the frame SHALL complete; otherwise frame_err SHALL pulse. Either way the FSM SHALL return to IDLE.
REQ-019 Odd parity SHALL be checked: the XOR of the 8 data bits and the parity bit equals 1.
REQ-020 On completion with byte 0xF0: set break_pend and do not assert code_valid.
REQ-021 On completion with byte 0xE0: set ext_pend and do not assert code_valid.
REQ-022 On completion with any other byte:
- code updates to the byte;
- key_break and key_ext update to break_pend and ext_pend;
- code_valid is 1 for exactly one cycle;
- both pending flags clear.
REQ-023 code_valid SHALL rise in the clk cycle immediately after the cycle in which the stop-bit edge is detected.
REQ-024 code, key_break and key_ext SHALL hold their values between strobes.
REQ-025 In any non-IDLE state, an idle counter SHALL reset on each edge; when it reaches TIMEOUT_CYC, the FSM SHALL go to IDLE and frame_err SHALL pulse.
REQ-026 Any frame_err SHALL also clear break_pend and ext_pend.
REQ-027 code_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst_n is 0, regardless of clk:
- the FSM is in IDLE, with counters and pending flags cleared;
- code is 0x00; code_valid, key_break, key_ext and frame_err are 0;
- synchronizer stages are 1, so release cannot create a false edge.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN defined: a parity mismatch SHALL discard the frame and pulse frame_err.
REQ-031 Macro PS2_PARITY_CHECK_EN undefined: the parity bit SHALL be sampled and ignored; only a bad stop bit or a timeout produce frame_err.

Verification
REQ-032 Frame 0x1C with parity 0 and stop 1 -> code=0x1C, code_valid high for 1 cycle, key_break=0, key_ext=0.
REQ-033 Frames F0 then 1C -> exactly one code_valid, with code=0x1C and key_break=1; a following 1C frame gives key_break=0.
REQ-034 Frames E0, F0, 75 -> one code_valid, with code=0x75, key_ext=1, key_break=1.
REQ-035 Frame 0x1C with parity 1 -> with the macro: frame_err pulse and no code_valid; without the macro: code_valid with code=0x1C.
REQ-036 Frame 0x1C with stop bit 0 -> frame_err pulse and code unchanged; a frame that stops after 4 data bits plus TIMEOUT_CYC idle cycles -> frame_err pulse, and the next 0x29 frame is received correctly.
REQ-037 rst_n pulsed low after 5 data bits -> all outputs 0, no frame_err; the next 0x1C frame gives code_valid with code=0x1C.
